// File: rtl/trace_pkg.sv
// Shared types and constants for the pipeline trace buffer.
// Optional feature macro: TRACE_TIMESTAMP_EN (adds a 32-bit timestamp per entry).
package trace_pkg;

  localparam int TR_DATA_W = 32;
  localparam int TS_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_FROZEN  = 2'd3
  } trace_state_t;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  typedef struct packed {
    logic                 kind;
    logic [TR_DATA_W-1:0] tag;
    logic [TR_DATA_W-1:0] data;
    logic [TR_DATA_W-1:0] pc;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]      ts;
`endif
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port storage for trace entries: one synchronous write port,
// one synchronous read port, read-before-write on a same-slot collision.
// Contents are deliberately not reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and read in one process; the non-blocking write keeps the read old.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Circular trace capture of WB register writebacks and MEM stores with a
// PC-match trigger and a post-trigger count that freezes the buffer.
// DATA_W must match trace_pkg::TR_DATA_W (entry fields are sized there).
// Optional feature macro: TRACE_TIMESTAMP_EN (adds rd_ts and a cycle counter).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | not capturing; arm starts capture
// CAPTURE | storing events, watching for trigger PC
// POST    | trigger seen; storing `remaining` more entries
// FROZEN  | buffer held for readout; only clear/reset leave
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int DROP_W = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              clear,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_wraddr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wrdata,
  input  logic [DATA_W-1:0] mem_pc,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [IDX_W-1:0]  post_cnt,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              rd_kind,
  output logic [DATA_W-1:0] rd_tag,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_pc,
  output logic [1:0]        state,
  output logic [IDX_W:0]    count,
  output logic              wrapped,
  output logic              triggered,
  output logic [DROP_W-1:0] dropped_cnt
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]       rd_ts
`endif
);

  localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(DEPTH - 1);

  trace_state_t     state_q, state_d;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] remaining_q, remaining_d;
  logic             set_trig;

  logic             reg_ev, mem_ev, capturing, store, collide;
  trace_entry_t     wr_entry, rd_entry;
  logic [ENTRY_W-1:0] ram_rdata;
  logic [IDX_W-1:0] rd_slot;
  logic             rd_in_range;
  logic             rd_hit_q;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  // Free-running cycle counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  // Event qualification and entry assembly; a REG event beats a MEM event.
  always_comb begin
    reg_ev    = wb_regwrite && (wb_wraddr != 5'd0);
    mem_ev    = mem_memwrite;
    capturing = (state_q == ST_CAPTURE) || (state_q == ST_POST);
    store     = capturing && !clear && (reg_ev || mem_ev);
    collide   = capturing && !clear && reg_ev && mem_ev;
    wr_entry  = '0;
    if (reg_ev) begin
      wr_entry.kind = KIND_REG;
      wr_entry.tag  = {{(DATA_W-5){1'b0}}, wb_wraddr};
      wr_entry.data = wb_data;
      wr_entry.pc   = wb_pc;
    end else begin
      wr_entry.kind = KIND_MEM;
      wr_entry.tag  = mem_addr;
      wr_entry.data = mem_wrdata;
      wr_entry.pc   = mem_pc;
    end
`ifdef TRACE_TIMESTAMP_EN
    wr_entry.ts = ts_cnt;
`endif
  end

  // Next-state logic: trigger detection and post-trigger countdown.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    set_trig    = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (store && trig_en && (wr_entry.pc == trig_pc)) begin
            set_trig    = 1'b1;
            remaining_d = post_cnt;
            state_d     = (post_cnt == '0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          if (store) begin
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == IDX_W'(1)) state_d = ST_FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  // State, write pointer, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      wrapped     <= 1'b0;
      triggered   <= 1'b0;
      dropped_cnt <= '0;
    end else if (clear) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      wrapped     <= 1'b0;
      triggered   <= 1'b0;
      dropped_cnt <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      if (set_trig) triggered <= 1'b1;
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != DEPTH_CNT) count <= count + 1'b1;
        if (wr_ptr == PTR_LAST) wrapped <= 1'b1;
      end
      if (collide && (dropped_cnt != '1)) dropped_cnt <= dropped_cnt + 1'b1;
    end
  end

  assign state = state_q;

  // Logical index is relative to the oldest entry.
  always_comb begin
    rd_slot     = (wrapped ? wr_ptr : '0) + rd_idx;
    rd_in_range = ({1'b0, rd_idx} < count);
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (rd_en && rd_in_range),
    .raddr (rd_slot),
    .rdata (ram_rdata)
  );

  // Read status pulses; rd_hit_q gates the held fields so reset and
  // out-of-range reads present zeros instead of stale RAM contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      rd_valid <= rd_en && rd_in_range;
      rd_err   <= rd_en && !rd_in_range;
      if (rd_en) rd_hit_q <= rd_in_range;
    end
  end

  // Present the held RAM word as entry fields.
  always_comb begin
    rd_entry = trace_entry_t'(ram_rdata);
    rd_kind  = rd_hit_q ? rd_entry.kind : 1'b0;
    rd_tag   = rd_hit_q ? rd_entry.tag  : '0;
    rd_data  = rd_hit_q ? rd_entry.data : '0;
    rd_pc    = rd_hit_q ? rd_entry.pc   : '0;
`ifdef TRACE_TIMESTAMP_EN
    rd_ts    = rd_hit_q ? rd_entry.ts   : '0;
`endif
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH=16, DATA_W=32).
module tb_wb_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int DROP_W = 8;
  localparam int IDX_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              arm, clear;
  logic              wb_regwrite;
  logic [4:0]        wb_wraddr;
  logic [DATA_W-1:0] wb_data, wb_pc;
  logic              mem_memwrite;
  logic [DATA_W-1:0] mem_addr, mem_wrdata, mem_pc;
  logic              trig_en;
  logic [DATA_W-1:0] trig_pc;
  logic [IDX_W-1:0]  post_cnt;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid, rd_err, rd_kind;
  logic [DATA_W-1:0] rd_tag, rd_data, rd_pc;
  logic [1:0]        state;
  logic [IDX_W:0]    count;
  logic              wrapped, triggered;
  logic [DROP_W-1:0] dropped_cnt;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]       rd_ts;
`endif

  int total = 0;
  int bad   = 0;

  wb_trace_buffer #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .DROP_W(DROP_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .clear(clear),
    .wb_regwrite(wb_regwrite), .wb_wraddr(wb_wraddr), .wb_data(wb_data), .wb_pc(wb_pc),
    .mem_memwrite(mem_memwrite), .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_pc(mem_pc),
    .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_err(rd_err), .rd_kind(rd_kind),
    .rd_tag(rd_tag), .rd_data(rd_data), .rd_pc(rd_pc),
    .state(state), .count(count), .wrapped(wrapped), .triggered(triggered),
    .dropped_cnt(dropped_cnt)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_ts(rd_ts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic              valid;
    logic              err;
    logic              kind;
    logic [DATA_W-1:0] tag;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } rd_vec_t;

  rd_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 0; clear = 0; wb_regwrite = 0; wb_wraddr = '0; wb_data = '0; wb_pc = '0;
    mem_memwrite = 0; mem_addr = '0; mem_wrdata = '0; mem_pc = '0;
    trig_en = 0; trig_pc = '0; post_cnt = '0; rd_en = 0; rd_idx = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    step();
    step();
    reset = 1;
  endtask

  task automatic do_arm();
    arm = 1;
    step();
    arm = 0;
  endtask

  task automatic reg_wr(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    wb_regwrite = 1; wb_wraddr = r; wb_data = d; wb_pc = pc;
    step();
    wb_regwrite = 0;
  endtask

  task automatic do_read(input logic [IDX_W-1:0] idx);
    rd_en = 1; rd_idx = idx;
    step();
    rd_en = 0;
  endtask

  initial begin
    // idx, valid, err, kind, tag, data, pc  (count = 3 when applied)
    vecs[0] = '{4'd0, 1'b1, 1'b0, 1'b0, 32'd8,  32'h11, 32'h0};
    vecs[1] = '{4'd1, 1'b1, 1'b0, 1'b0, 32'd9,  32'h22, 32'h4};
    vecs[2] = '{4'd2, 1'b1, 1'b0, 1'b0, 32'd16, 32'h33, 32'h8};
    vecs[3] = '{4'd5, 1'b0, 1'b1, 1'b0, 32'd0,  32'h0,  32'h0};
    vecs[4] = '{4'd3, 1'b0, 1'b1, 1'b0, 32'd0,  32'h0,  32'h0};
    vecs[5] = '{4'd2, 1'b1, 1'b0, 1'b0, 32'd16, 32'h33, 32'h8};

    // Reset values and basic capture.
    do_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    check("rst_trig", 32'(triggered), 32'd0);
    check("rst_dropped", 32'(dropped_cnt), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    do_arm();
    check("arm_state", 32'(state), 32'd1);
    reg_wr(5'd8, 32'h11, 32'h0);
    reg_wr(5'd9, 32'h22, 32'h4);
    reg_wr(5'd16, 32'h33, 32'h8);
    check("t1_count", 32'(count), 32'd3);
    check("t1_wrapped", 32'(wrapped), 32'd0);
    for (int i = 0; i < 6; i++) begin
      do_read(vecs[i].idx);
      check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d_err", i), 32'(rd_err), 32'(vecs[i].err));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d_kind", i), 32'(rd_kind), 32'(vecs[i].kind));
        check($sformatf("vec%0d_tag", i), rd_tag, vecs[i].tag);
        check($sformatf("vec%0d_data", i), rd_data, vecs[i].data);
        check($sformatf("vec%0d_pc", i), rd_pc, vecs[i].pc);
      end
      step();
      check($sformatf("vec%0d_pulse", i), 32'({rd_valid, rd_err}), 32'd0);
    end

    // Wraparound: 20 writes into 16 slots, oldest kept is data 5.
    do_reset();
    do_arm();
    for (int i = 1; i <= 20; i++) reg_wr(5'd1, 32'(i), 32'(i * 4));
    check("t2_count", 32'(count), 32'd16);
    check("t2_wrapped", 32'(wrapped), 32'd1);
    do_read(4'd0);
    check("t2_idx0_data", rd_data, 32'd5);
    check("t2_idx0_pc", rd_pc, 32'd20);
    do_read(4'd15);
    check("t2_idx15_data", rd_data, 32'd20);
    check("t2_idx15_valid", 32'(rd_valid), 32'd1);

    // Trigger with post count 2.
    do_reset();
    trig_en = 1; trig_pc = 32'h1C; post_cnt = 4'd2;
    do_arm();
    for (int pc = 32'h10; pc <= 32'h28; pc += 4) begin
      reg_wr(5'd3, 32'(pc), 32'(pc));
      if (pc == 32'h1C) begin
        check("t3_post_state", 32'(state), 32'd2);
        check("t3_triggered", 32'(triggered), 32'd1);
      end
      if (pc == 32'h24) check("t3_frozen", 32'(state), 32'd3);
    end
    check("t3_count", 32'(count), 32'd6);
    do_read(4'd5);
    check("t3_idx5_pc", rd_pc, 32'h24);
    do_read(4'd3);
    check("t3_idx3_pc", rd_pc, 32'h1C);
    do_arm();
    check("t3_arm_ignored", 32'(state), 32'd3);

    // Collision, $zero write, lone store.
    do_reset();
    do_arm();
    wb_regwrite = 1; wb_wraddr = 5'd8; wb_data = 32'hAA; wb_pc = 32'h100;
    mem_memwrite = 1; mem_addr = 32'h200; mem_wrdata = 32'hBB; mem_pc = 32'h104;
    step();
    wb_regwrite = 0; mem_memwrite = 0;
    check("t4_col_count", 32'(count), 32'd1);
    check("t4_dropped", 32'(dropped_cnt), 32'd1);
    reg_wr(5'd0, 32'h55, 32'h10C);
    check("t4_r0_count", 32'(count), 32'd1);
    mem_memwrite = 1; mem_addr = 32'h40; mem_wrdata = 32'h7; mem_pc = 32'h108;
    step();
    mem_memwrite = 0;
    check("t4_store_count", 32'(count), 32'd2);
    do_read(4'd1);
    check("t4_mem_kind", 32'(rd_kind), 32'd1);
    check("t4_mem_tag", rd_tag, 32'h40);
    check("t4_mem_data", rd_data, 32'h7);
    check("t4_mem_pc", rd_pc, 32'h108);
    do_read(4'd0);
    check("t4_reg_kind", 32'(rd_kind), 32'd0);
    check("t4_reg_tag", rd_tag, 32'd8);
    check("t4_reg_data", rd_data, 32'hAA);

    // Reset during POST, with a read issued in the same cycle.
    do_reset();
    trig_en = 1; trig_pc = 32'h8; post_cnt = 4'd3;
    do_arm();
    reg_wr(5'd4, 32'hA0, 32'h0);
    reg_wr(5'd5, 32'hA4, 32'h4);
    reg_wr(5'd6, 32'hA8, 32'h8);
    check("t5_post", 32'(state), 32'd2);
    do_read(4'd0);
    check("t5_pre_data", rd_data, 32'hA0);
    reset = 0; rd_en = 1; rd_idx = 4'd1;
    step();
    rd_en = 0; reset = 1;
    check("t5_rst_state", 32'(state), 32'd0);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_trig", 32'(triggered), 32'd0);
    check("t5_rst_valid", 32'(rd_valid), 32'd0);
    check("t5_rst_err", 32'(rd_err), 32'd0);
    check("t5_rst_data", rd_data, 32'd0);
    check("t5_rst_tag", rd_tag, 32'd0);
    check("t5_rst_pc", rd_pc, 32'd0);

    // Immediate freeze (post_cnt 0), then clear.
    trig_en = 1; trig_pc = 32'h4; post_cnt = 4'd0;
    do_arm();
    reg_wr(5'd7, 32'h1, 32'h0);
    reg_wr(5'd7, 32'h2, 32'h4);
    check("t5_frz_state", 32'(state), 32'd3);
    check("t5_frz_count", 32'(count), 32'd2);
    clear = 1;
    wb_regwrite = 1; wb_wraddr = 5'd9; wb_pc = 32'h8;
    step();
    clear = 0; wb_regwrite = 0;
    check("t5_clr_state", 32'(state), 32'd0);
    check("t5_clr_count", 32'(count), 32'd0);
    check("t5_clr_trig", 32'(triggered), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
On-chip circular trace capture for the 5-stage MIPS pipeline. It records register writebacks and data-memory stores, each tagged with its PC, into a parametrised ring buffer. A PC-match trigger with a programmable post-trigger count freezes the buffer. The trace is read back by index, oldest entry first. It sits beside the pipeline top and taps the WB and MEM stage signals.

Parameters:
DEPTH, 16, ring entries (power of 2, min 4)
DATA_W, 32, data/PC/address width
DROP_W, 8, width of the dropped-event counter (saturating)
IDX_W, $clog2(DEPTH), index width (derived)

Ports:
clk  in  1  clock, all logic on the rising edge
reset  in  1  synchronous, active-low; sampled at the clk rising edge
arm  in  1  start capture (IDLE only)
clear  in  1  return to IDLE and empty the buffer
wb_regwrite  in  1  WB-stage register write enable
wb_wraddr  in  5  WB destination register
wb_data  in  DATA_W  WB result
wb_pc  in  DATA_W  PC of the WB instruction
mem_memwrite  in  1  MEM-stage store enable
mem_addr  in  DATA_W  store address
mem_wrdata  in  DATA_W  store data
mem_pc  in  DATA_W  PC of the MEM instruction
trig_en  in  1  trigger enable
trig_pc  in  DATA_W  trigger PC
post_cnt  in  IDX_W  entries to capture after the trigger entry
rd_en  in  1  read request
rd_idx  in  IDX_W  logical index, 0 = oldest
rd_valid  out  1  read data valid
rd_err  out  1  index out of range
rd_kind  out  1  0 = REG, 1 = MEM
rd_tag  out  DATA_W  register number (zero-extended) or store address
rd_data  out  DATA_W  entry data
rd_pc  out  DATA_W  entry PC
state  out  2  IDLE=0, CAPTURE=1, POST=2, FROZEN=3
count  out  IDX_W+1  valid entries (0..DEPTH)
wrapped  out  1  ring has overwritten at least once
triggered  out  1  trigger has fired
dropped_cnt  out  DROP_W  MEM events lost to collisions

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; wr_ptr=0; count=0; wrapped=0; triggered=0; dropped_cnt=0; rd_valid/rd_err/rd_kind/rd_tag/rd_data/rd_pc=0. RAM contents are not reset.
- Event selection in CAPTURE/POST:
  - REG event = wb_regwrite && wb_wraddr!=0. Writes to $zero are never stored.
  - A REG event is stored in preference to a MEM event. If both occur in the same cycle, the REG event is stored and dropped_cnt increments, saturating at all-ones.
  - A MEM event alone is stored with kind=MEM and pc=mem_pc.
- Each stored entry is written at wr_ptr; wr_ptr then increments mod DEPTH. count increments, saturating at DEPTH. wrapped is set when wr_ptr wraps from DEPTH-1 to 0.
- State transitions:
  - IDLE: nothing is stored. arm -> CAPTURE.
  - CAPTURE: if trig_en and the stored entry's PC == trig_pc, the entry is stored and triggered=1, remaining=post_cnt. Next state is POST, or FROZEN if post_cnt==0.
  - POST: each stored entry decrements remaining; when remaining reaches 0 -> FROZEN. Further trigger matches are ignored.
  - FROZEN: no stores; arm ignored.
- Priority: clear (any state) > arm/capture. On clear: state=IDLE; wr_ptr, count, wrapped, triggered, dropped_cnt are zeroed; that cycle's event is not stored.
- Readout:
  - Legal in every state, with 1-cycle latency.
  - Physical slot = (wrapped ? wr_ptr : 0) + rd_idx, mod DEPTH, using wr_ptr/count as of the request cycle.
  - rd_idx < count -> rd_valid=1 for one cycle with the entry fields.
  - Otherwise rd_valid=0 and rd_err=1 for one cycle.
  - A read and a write to the same slot in the same cycle return the old contents (read-before-write).
  - Output fields hold their value until the next read.
- If reset is asserted mid-capture or mid-read, it wins; the reset values appear on the next edge.

Optional Feature:
TRACE_TIMESTAMP_EN:
- Defined: a free-running 32-bit cycle counter (zeroed by reset only) is stored in each entry and presented on an extra output port rd_ts[31:0], with the same timing as rd_data.
- Undefined: no counter, no rd_ts port, and the entry width is unchanged.

Decomposition:
- Package trace_pkg holds:
  - the state encoding (IDLE/CAPTURE/POST/FROZEN)
  - KIND_REG=0 / KIND_MEM=1
  - the entry struct {kind, tag, data, pc[, ts]}
  - the ENTRY_W constant
- One sub-module, trace_ram: DEPTH x ENTRY_W, one synchronous write port and one synchronous read port, read-before-write, no reset.

Test Plan:
1. Reset, arm, then REG writes r8=0x11 @pc 0x0, r9=0x22 @0x4, r16=0x33 @0x8. Read idx 0..2 -> tags 8/9/16 in order, data 0x11/0x22/0x33; count=3, wrapped=0.
2. DEPTH=16, 20 REG writes with data 1..20. -> count=16, wrapped=1; idx0 data=5, idx15 data=20.
3. trig_en=1, trig_pc=0x1C, post_cnt=2, REG writes at pcs 0x10..0x28 step 4. -> state=FROZEN after the 0x24 entry; count=6; idx5 pc=0x24; the 0x28 write is not stored.
4. Same cycle: wb_regwrite to r8 and mem_memwrite. -> one REG entry stored, dropped_cnt=1. A write to r0 leaves count unchanged. A lone store (addr 0x40, data 0x7) -> kind=MEM, tag=0x40.
5. reset=0 during POST -> next cycle IDLE, count=0, triggered=0, all rd_* outputs=0. In a separate run, clear in FROZEN -> IDLE, count=0.
6. With count=3, rd_idx=5 -> rd_err=1, rd_valid=0 one cycle later. With count=3, rd_idx=2 -> rd_valid=1, rd_err=0.
